uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameters SHALL be as follows:
- NUM_REQ, default 4: number of requester channels, range 2..8.
- DATA_WIDTH, default 8: word width, equal to the uart tx_data width.
- MAX_BURST, default 16: maximum words per grant, range 1..256.
- IDLE_TIMEOUT, default 64: number of stall cycles before a grant is forcibly released, range 1..1024.

REQ-002 Ports SHALL be as follows:
- clk  in  1  sole clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester word valid.
- req_data  in  NUM_REQ*DATA_WIDTH  requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  NUM_REQ  marks the final word of a packet.
- req_ready  out  NUM_REQ  word accepted when valid and ready are both high.
- tx_data  out  DATA_WIDTH  to uart tx_data.
- tx_write  out  1  to uart tx_write.
- tx_full  in  1  from uart tx_full.
- grant  out  NUM_REQ  one-hot owner, all zero when idle.
- grant_id  out  clog2(NUM_REQ)  encoded owner, valid when busy.
- busy  out  1  high in GRANT state.
- timeout_pulse  out  1  one-cycle pulse on forced release.

REQ-003 Clock and reset: one clock domain; reset is synchronous and active-high; no other clocks or asynchronous inputs.

Function
REQ-004 The block SHALL implement a two-state FSM, IDLE and GRANT, with state, grant, pointer and counters all registered.
REQ-005 In IDLE with any req_valid high, the block SHALL select the first valid requester searching round-robin from index (last_owner+1) mod NUM_REQ, register it, and enter GRANT on the next cycle.
- Arbitration latency is 1 cycle from req_valid to grant.
REQ-006 In IDLE, grant, req_ready, tx_write and busy SHALL be 0, and tx_data SHALL be 0.
REQ-007 In GRANT:
- req_ready[owner] = !tx_full; all other req_ready bits = 0.
- tx_write = req_valid[owner] && !tx_full, combinational.
- tx_data = req_data of the owner, combinational.
REQ-008 No word SHALL be written while tx_full is high, and no word SHALL be lost or duplicated; each valid&&ready cycle produces exactly one tx_write.
REQ-009 Burst counter:
- Cleared on entry to GRANT.
- Incremented per transferred word.
- Width clog2(MAX_BURST+1).
- Never wraps.
REQ-010 GRANT SHALL return to IDLE on the cycle after a transfer whose req_last is 1, or whose transfer brings the burst count to MAX_BURST, whichever occurs first.
- last_owner <= owner at that point.
REQ-011 If the owner drops req_valid mid-packet, the grant SHALL be held (packet lock); other requesters remain blocked.
REQ-012 Stall counter:
- Counts consecutive GRANT cycles with no transfer, whether caused by tx_full or by !req_valid[owner].
- Clears on any transfer.
- On reaching IDLE_TIMEOUT, the block SHALL pulse timeout_pulse for 1 cycle, go to IDLE, and set last_owner <= owner.
REQ-013 Simultaneous events, in priority order:
- A transfer on the same cycle the stall count would expire counts as a transfer; no timeout occurs.
- last and MAX_BURST on the same word cause a single release.
REQ-014 Back-to-back packets: minimum 1 IDLE cycle between grants; a requester holding req_valid continuously is re-granted only if no other requester is valid (fairness).
REQ-015 req_data and req_last of non-owners SHALL be ignored; changes on a non-owner have no effect on the outputs.
REQ-016 grant_id SHALL hold the last owner's index while IDLE; grant is authoritative.

Reset
REQ-017 While rst is high at a clk edge, the next state SHALL be:
- state = IDLE.
- grant = 0, busy = 0, timeout_pulse = 0.
- Burst and stall counters = 0.
- last_owner = NUM_REQ-1, so requester 0 wins first.
REQ-018 Reset asserted mid-packet SHALL abort the grant with no further tx_write after the reset edge; the partially sent packet is not resumed.
REQ-019 Outputs derived combinationally from state SHALL be 0 in the cycle following the reset edge regardless of the req_* inputs.

Verification
REQ-020 Reset release, all 4 requesters valid with 1-word packets (last=1) -> grants 0,1,2,3,0 in order, one tx_write each, 1 IDLE cycle between grants.
REQ-021 Requester 2 sends a 5-word packet, data 0xA0..0xA4, last on word 5, while tx_full is high for 3 cycles after word 2 -> tx_write pulses carry exactly A0..A4 in order; no write while full; grant held throughout.
REQ-022 With MAX_BURST=16, requester 1 sends 20 words with no last -> release after word 16, then regrant to requester 1 (sole requester) for words 17..20.
REQ-023 With IDLE_TIMEOUT=64, the owner drops valid after word 3 -> timeout_pulse on stall cycle 64, busy falls, a waiting requester 3 is granted next.
REQ-024 rst asserted during word 4 of an 8-word packet -> no tx_write after the reset edge, grant=0, and after release requester 0 wins if valid.
REQ-025 Random valid/tx_full traffic over 10k cycles -> scoreboard per-requester word order matches, no drops or duplicates, and no requester waits more than NUM_REQ grants.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that multiplexes NUM_REQ packet streams onto one UART transmitter.
// A grant is held for a whole packet, capped at MAX_BURST words or IDLE_TIMEOUT stall cycles.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned IDLE_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_write,
  input  logic                          tx_full,
  output logic [NUM_REQ-1:0]            grant,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          timeout_pulse
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);
  localparam int unsigned BW   = $clog2(MAX_BURST + 1);
  localparam int unsigned SW   = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [ID_W-1:0] LAST_ID    = ID_W'(NUM_REQ - 1);
  localparam logic [BW-1:0]   BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [SW-1:0]   STALL_LAST = SW'(IDLE_TIMEOUT - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state;
  logic [ID_W-1:0]       owner;
  logic [BW-1:0]         burst_cnt;
  logic [SW-1:0]         stall_cnt;
  logic [ID_W-1:0]       cand;
  logic [ID_W-1:0]       pick;
  logic                  pick_ok;
  logic                  owner_valid;
  logic                  owner_last;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] words [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign words[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // owner keeps its value after release, so it doubles as the round-robin pointer
  always_comb begin
    cand    = owner;
    pick    = owner;
    pick_ok = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = (cand == LAST_ID) ? '0 : cand + 1'b1;
      if (!pick_ok && req_valid[cand]) begin
        pick_ok = 1'b1;
        pick    = cand;
      end
    end
  end

  assign owner_valid = req_valid[owner];
  assign owner_last  = req_last[owner];
  assign xfer        = (state == GRANT) && owner_valid && !tx_full;

  assign tx_write  = xfer;
  assign tx_data   = (state == GRANT) ? words[owner] : '0;
  assign req_ready = grant & {NUM_REQ{!tx_full}};
  assign grant_id  = owner;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      grant         <= '0;
      busy          <= 1'b0;
      timeout_pulse <= 1'b0;
      burst_cnt     <= '0;
      stall_cnt     <= '0;
      owner         <= LAST_ID;
    end else begin
      timeout_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_ok) begin
            state     <= GRANT;
            busy      <= 1'b1;
            owner     <= pick;
            grant     <= NUM_REQ'(1) << pick;
            burst_cnt <= '0;
            stall_cnt <= '0;
          end
        end
        GRANT: begin
          if (xfer) begin
            stall_cnt <= '0;
            burst_cnt <= burst_cnt + 1'b1;
            if (owner_last || burst_cnt == BURST_LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
              grant <= '0;
            end
          end else if (stall_cnt == STALL_LAST) begin
            state         <= IDLE;
            busy          <= 1'b0;
            grant         <= '0;
            timeout_pulse <= 1'b1;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scenarios plus random traffic for uart_tx_arbiter, checked every cycle against
// an integer-level packet/grant model; literal expectations pin the model on key scenarios.
module tb_uart_tx_arbiter;

  localparam int N            = 4;
  localparam int DW           = 8;
  localparam int IW           = 2;
  localparam int MAX_BURST    = 16;
  localparam int IDLE_TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_last;
  logic [N-1:0]  req_ready;
  logic [DW-1:0] tx_data;
  logic          tx_write;
  logic          tx_full;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_id;
  logic          busy;
  logic          timeout_pulse;

  uart_tx_arbiter #(
    .NUM_REQ(N),
    .DATA_WIDTH(DW),
    .MAX_BURST(MAX_BURST),
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .tx_data(tx_data),
    .tx_write(tx_write),
    .tx_full(tx_full),
    .grant(grant),
    .grant_id(grant_id),
    .busy(busy),
    .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  bit rnd_mode = 1'b0;

  // model state
  bit           m_busy = 1'b0;
  int           m_owner = N - 1;
  int           m_words = 0;
  int           m_stall = 0;
  bit           m_tpulse = 1'b0;
  logic [N-1:0] m_acc = '0;
  int           seq[N];
  int           exp_seq[N];
  int           wait_cnt[N];

  // observations of the DUT for the literal checks
  int gstart[$], gcyc[$], cap[$], lens[$], tq[$], tbusy[$];
  int cur_len = 0;
  int stall_run = 0;
  bit prev_busy = 1'b0;

  logic [N-1:0]  eg;
  logic          ew;
  logic [DW-1:0] ed;
  int            ow, g;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic bitof(logic [N-1:0] v, int k);
    logic [IW-1:0] idx;
    idx = IW'(k);
    return v[idx];
  endfunction

  function automatic logic [DW-1:0] word_of(int k);
    return DW'(req_data >> (k * DW));
  endfunction

  function automatic int rr_pick(int from, logic [N-1:0] v);
    for (int d = 1; d <= N; d++)
      if (bitof(v, (from + d) % N)) return (from + d) % N;
    return from;
  endfunction

  task automatic set_word(int k, logic [DW-1:0] v);
    logic [N*DW-1:0] m;
    m = (N*DW)'({DW{1'b1}}) << (k * DW);
    req_data = (req_data & ~m) | (((N*DW)'(v)) << (k * DW));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // per-cycle compare against the model, then advance the model across the coming edge
  always @(negedge clk) begin
    if (chk_en) begin
      cyc++;
      ow = m_owner;
      eg = m_busy ? N'(1 << ow) : '0;
      ew = m_busy && bitof(req_valid, ow) && !tx_full;
      ed = m_busy ? word_of(ow) : '0;
      chk("busy", busy, m_busy);
      chk("grant", grant, eg);
      chk("grant_id", grant_id, ow);
      chk("timeout_pulse", timeout_pulse, m_tpulse);
      chk("req_ready", req_ready, (m_busy && !tx_full) ? eg : '0);
      chk("tx_write", tx_write, ew);
      chk("tx_data", tx_data, ed);
      if (rnd_mode && ew) begin
        chk("sb_word", tx_data, (ow << 6) | (exp_seq[ow] % 64));
        exp_seq[ow]++;
      end

      if (tx_write) begin
        cap.push_back(int'(tx_data));
        cur_len++;
      end
      if (timeout_pulse) begin
        tq.push_back(stall_run);
        tbusy.push_back(int'(busy));
      end
      if (busy && !tx_write) stall_run++;
      else stall_run = 0;

      for (int i = 0; i < N; i++)
        if (!bitof(req_valid, i) || rst) wait_cnt[i] = 0;
      if (busy && !prev_busy) begin
        g = int'(grant_id);
        n_vec++;
        if (wait_cnt[g] > N) begin
          n_err++;
          $display("FAIL fair_wait: requester %0d waited %0d grants, limit %0d", g, wait_cnt[g], N);
        end
        wait_cnt[g] = 0;
        for (int i = 0; i < N; i++)
          if (i != g && bitof(req_valid, i)) wait_cnt[i]++;
        gstart.push_back(g);
        gcyc.push_back(cyc);
      end
      if (!busy && prev_busy) begin
        lens.push_back(cur_len);
        cur_len = 0;
      end
      prev_busy = busy;

      m_acc = ew ? eg : '0;
      if (rst) begin
        m_busy = 1'b0; m_owner = N - 1; m_words = 0; m_stall = 0; m_tpulse = 1'b0;
      end else begin
        m_tpulse = 1'b0;
        if (!m_busy) begin
          if (req_valid != '0) begin
            m_owner = rr_pick(m_owner, req_valid);
            m_busy = 1'b1; m_words = 0; m_stall = 0;
          end
        end else if (ew) begin
          m_words++;
          m_stall = 0;
          if (bitof(req_last, ow) || m_words == MAX_BURST) m_busy = 1'b0;
        end else begin
          m_stall++;
          if (m_stall == IDLE_TIMEOUT) begin
            m_busy = 1'b0;
            m_tpulse = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    int w, c, full_left;
    int exp20[5];
    logic [N-1:0] nv, nl;
    bit v;

    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; tx_full = 1'b0;
    for (int i = 0; i < N; i++) begin seq[i] = 0; exp_seq[i] = 0; wait_cnt[i] = 0; end

    // reset state with every requester asserting valid
    tick();
    chk_en = 1'b1; req_valid = '1; req_last = '1;
    @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 3);
    chk("rst_tx_write", tx_write, 0);
    chk("rst_req_ready", req_ready, 0);
    tick();
    rst = 1'b0;
    gstart.delete(); gcyc.delete(); cap.delete();

    // all four requesters, single-word packets
    repeat (10) tick();
    req_valid = '0; req_last = '0;
    exp20 = '{0, 1, 2, 3, 0};
    chk("t20_ngrants", gstart.size(), 5);
    for (int i = 0; i < 5 && i < gstart.size(); i++)
      chk($sformatf("t20_owner%0d", i), gstart[i], exp20[i]);
    for (int i = 1; i < gstart.size(); i++)
      chk($sformatf("t20_gap%0d", i), gcyc[i] - gcyc[i-1], 2);
    chk("t20_writes", cap.size(), 5);

    // requester 2, 5-word packet with tx_full stalling after word 2
    repeat (2) tick();
    gstart.delete(); cap.delete();
    w = 0; full_left = 0;
    for (c = 0; c < 60 && w < 5; c++) begin
      req_valid = 4'b0100;
      req_last = (w == 4) ? 4'b0100 : 4'b0000;
      set_word(2, 8'hA0 + 8'(w));
      tx_full = (full_left > 0);
      tick();
      if (tx_full) full_left--;
      if (m_acc[2]) begin
        w++;
        if (w == 2) full_left = 3;
      end
    end
    req_valid = '0; req_last = '0; tx_full = 1'b0;
    repeat (3) tick();
    chk("t21_words", w, 5);
    chk("t21_ncap", cap.size(), 5);
    for (int i = 0; i < cap.size() && i < 5; i++)
      chk($sformatf("t21_data%0d", i), cap[i], 32'hA0 + i);
    chk("t21_ngrants", gstart.size(), 1);

    // requester 1, 20 words with no last: burst cap, then regrant, then stall release
    gstart.delete(); lens.delete(); tq.delete();
    w = 0;
    for (c = 0; c < 200 && w < 20; c++) begin
      req_valid = 4'b0010; req_last = '0;
      set_word(1, 8'(w));
      tick();
      if (m_acc[1]) w++;
    end
    req_valid = '0;
    for (c = 0; c < 150 && lens.size() < 2; c++) tick();
    chk("t22_words", w, 20);
    chk("t22_nbursts", lens.size(), 2);
    chk("t22_burst0", lens.size() > 0 ? lens[0] : -1, 16);
    chk("t22_burst1", lens.size() > 1 ? lens[1] : -1, 4);
    chk("t22_owner0", gstart.size() > 0 ? gstart[0] : -1, 1);
    chk("t22_owner1", gstart.size() > 1 ? gstart[1] : -1, 1);
    chk("t22_ntimeouts", tq.size(), 1);

    // requester 0 drops valid after word 3 while requester 3 waits
    repeat (2) tick();
    gstart.delete(); tq.delete(); tbusy.delete();
    w = 0;
    for (c = 0; c < 40 && w < 3; c++) begin
      req_valid = 4'b0001; req_last = '0;
      set_word(0, 8'h30 + 8'(w));
      tick();
      if (m_acc[0]) w++;
    end
    req_valid = 4'b1000; req_last = 4'b1000; set_word(3, 8'h77);
    for (c = 0; c < 150 && tq.size() == 0; c++) @(posedge clk);
    @(negedge clk);
    chk("t23_grant_after", grant, 4'b1000);
    chk("t23_npulse", tq.size(), 1);
    chk("t23_stall", tq.size() > 0 ? tq[0] : -1, 64);
    chk("t23_busy_at_pulse", tbusy.size() > 0 ? tbusy[0] : 1, 0);
    chk("t23_first_owner", gstart.size() > 0 ? gstart[0] : -1, 0);
    @(posedge clk); #1;
    req_valid = '0; req_last = '0;
    repeat (3) tick();

    // reset during word 4 of an 8-word packet from requester 2
    w = 0;
    for (c = 0; c < 40 && w < 3; c++) begin
      req_valid = 4'b0100; req_last = '0;
      set_word(2, 8'h50 + 8'(w));
      tick();
      if (m_acc[2]) w++;
    end
    set_word(2, 8'h53);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 4'b0101; req_last = 4'b0101; set_word(0, 8'h11);
    cap.delete();
    @(negedge clk);
    chk("t24_tx_write", tx_write, 0);
    chk("t24_grant", grant, 0);
    chk("t24_busy", busy, 0);
    @(negedge clk);
    chk("t24_regrant", grant, 4'b0001);
    @(posedge clk); #1;
    req_valid = '0; req_last = '0;
    repeat (3) tick();
    chk("t24_words_before", w, 3);
    chk("t24_ncap", cap.size(), 1);
    chk("t24_cap0", cap.size() > 0 ? cap[0] : -1, 32'h11);

    // random traffic
    repeat (2) tick();
    for (int i = 0; i < N; i++) begin seq[i] = 0; exp_seq[i] = 0; end
    rnd_mode = 1'b1;
    for (int c2 = 0; c2 < 10000; c2++) begin
      nv = '0; nl = '0;
      for (int i = 0; i < N; i++) begin
        if (bitof(m_acc, i)) seq[i]++;
        if (bitof(req_valid, i) && !bitof(m_acc, i)) v = ($urandom_range(0, 99) < 95);
        else v = ($urandom_range(0, 99) < 40);
        nv = nv | (N'(v) << i);
        nl = nl | (N'($urandom_range(0, 3) == 0) << i);
        set_word(i, DW'((i << 6) | (seq[i] % 64)));
      end
      req_valid = nv; req_last = nl;
      tx_full = ($urandom_range(0, 99) < 25) || ((c2 % 2500) >= 2400);
      tick();
    end
    req_valid = '0; req_last = '0; tx_full = 1'b0;
    for (c = 0; c < 200 && busy; c++) tick();
    rnd_mode = 1'b0;
    chk("end_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached after %0d cycles", cyc);
    $fatal(1, "time limit");
  end

endmodule
